sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one EXT_SRAM 16-bit port between two 32-bit word requesters: I (fetch) and D (load/store).
//  Arbitrates round-robin and splits each word access into two 16-bit SRAM beats (low, then high).
//  Drives SRAM valid/rw/addri/dtw, samples din, and returns a one-cycle ready pulse to the owner.
// PARAMETERS
//  BEAT_CYCLES  3  cycles sram_valid is held per 16-bit beat; din sampled on the last one (>=1)
// PORTS
//  clk          in   1   single clock, all state on posedge
//  nrst         in   1   reset, asynchronous, active-low
//  i_valid      in   1   I request; hold with i_rw/i_addr/i_dtw stable until i_ready
//  i_rw         in   1   1=write, 0=read
//  i_addr       in   32  byte address; [1:0] ignored (word aligned)
//  i_dtw        in   32  write data
//  i_ready      out  1   one-cycle completion pulse to I
//  d_valid, d_rw, d_addr, d_dtw, d_ready   same widths and rules as the I port
//  dtr          out  32  read data, shared by both ports; valid in the ready cycle
//  sram_valid   out  1   to EXT_SRAM valid
//  sram_rw      out  1   to EXT_SRAM rw
//  sram_addri   out  32  to EXT_SRAM addri
//  sram_dtw     out  16  to EXT_SRAM dtw
//  sram_din     in   16  from EXT_SRAM din
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE; last_d=1; dtr, all ready/sram_* outputs, busy = 0.
//   Any in-flight access is dropped: no ready is issued and the SRAM sees valid fall immediately.
//  FSM: IDLE -> LO -> GAP -> HI -> DONE -> IDLE.
//   LO and HI each last BEAT_CYCLES cycles (beat counter); GAP and DONE last 1 cycle.
//  IDLE: if i_valid|d_valid, grant and latch rw/addr/dtw/owner, go to LO.
//   Both valid: grant the port not served last (last_d=1 -> I, last_d=0 -> D); else grant the only one.
//  LO: sram_valid=1, sram_addri={a[31:2],2'b00}, sram_dtw=dtw[15:0].
//   On reads, dtr[15:0] <= sram_din on the last LO cycle.
//  GAP: sram_valid=0, sram_addri=0, sram_dtw=0 (mandatory idle beat between SRAM accesses).
//  HI: sram_valid=1, sram_addri={a[31:2],2'b10}, sram_dtw=dtw[31:16].
//   On reads, dtr[31:16] <= sram_din on the last HI cycle.
//  DONE: owner's ready=1 for exactly one cycle; last_d <= owner; go to IDLE.
//  sram_rw = latched rw in LO/GAP/HI, else 0. sram_dtw=0 whenever rw=0 or sram_valid=0.
//  Latency: request sampled in IDLE at cycle t -> ready in cycle t+2*BEAT_CYCLES+2 (t+8 at default).
//   Issue interval is 2*BEAT_CYCLES+3 (9 at default).
//  Writes leave dtr unchanged. Requests made while busy are not seen until IDLE.
//  Valid still high in the cycle after ready is a new request.
//  No address carry: 0xFFFF_FFFC -> beats at 0xFFFF_FFFC and 0xFFFF_FFFE, no wrap into 0.
//  Changes to a granted port's inputs after grant are ignored (latched copy is used).
//  Two ready outputs are never high together; ready never asserts outside DONE.
// STRUCTURE
//  sram_defs.vh: state encodings (IDLE, LO, GAP, HI, DONE), HALF_LO/HALF_HI offsets, beat counter width.
//  Sub-module rr_arb2: 2-way round-robin arbiter.
//   In: req_i, req_d, last_d. Out: gnt_d. Purely combinational.
//  Top: FSM, beat counter, request latch, dtr register.
// TESTING
//  1 I read 0x0000_1000; din=0xBEEF in LO, 0xDEAD in HI
//    -> addri 0x1000 x3, 0 x1, 0x1002 x3; i_ready at t+8; dtr=0xDEADBEEF.
//  2 D write 0x0000_2006 data 0x1234_5678
//    -> addri 0x2004 with dtw 0x5678, then 0x2006 with dtw 0x1234; sram_rw=1 in both beats.
//    -> d_ready at t+8; dtr unchanged.
//  3 I and D valid in the same cycle, both held for 3 requests each
//    -> grant order I,D,I,D,I,D; ready pulses 9 cycles apart; never both ready.
//  4 nrst low in the 2nd HI cycle
//    -> sram_valid=0, busy=0 at once; no ready; after release, a fresh I read completes normally.
//  5 Read at 0xFFFF_FFFC -> beats at 0xFFFF_FFFC and 0xFFFF_FFFE; no access at 0x0.
//  6 i_addr changed to 0x5000 during LO of a 0x4000 read
//    -> both beats still use 0x4000/0x4002.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port word to 16-bit SRAM arbiter.
// State encodings, half-word offsets and beat counter sizing.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    GAP,
    HI,
    DONE
  } state_e;

  localparam logic [1:0] HALF_LO = 2'b00;
  localparam logic [1:0] HALF_HI = 2'b10;

  typedef struct packed {
    logic        own_d;
    logic        rw;
    logic [29:0] wa;
    logic [31:0] dtw;
  } req_t;

  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester ports, shared read data and EXT_SRAM port of the arbiter.
// slave faces the arbiter, master faces requesters and the SRAM.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic        i_valid;
  logic        i_rw;
  logic [31:0] i_addr;
  logic [31:0] i_dtw;
  logic        i_ready;

  logic        d_valid;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_dtw;
  logic        d_ready;

  logic [31:0] dtr;
  logic        busy;

  logic        sram_valid;
  logic        sram_rw;
  logic [31:0] sram_addri;
  logic [15:0] sram_dtw;
  logic [15:0] sram_din;

  modport slave (
    input  i_valid, i_rw, i_addr, i_dtw,
    input  d_valid, d_rw, d_addr, d_dtw,
    input  sram_din,
    output i_ready, d_ready, dtr, busy,
    output sram_valid, sram_rw,
    output sram_addri, sram_dtw
  );

  modport master (
    output i_valid, i_rw, i_addr, i_dtw,
    output d_valid, d_rw, d_addr, d_dtw,
    output sram_din,
    input  i_ready, d_ready, dtr, busy,
    input  sram_valid, sram_rw,
    input  sram_addri, sram_dtw
  );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant between I and D requesters.
// Ties go to the side that was not served last.
module rr_arb2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic gnt_d
);

  assign gnt_d = req_d & (~req_i | ~last_d);

endmodule

// File: rtl/sram_arbiter.sv
// Splits 32-bit word accesses from I and D into two 16-bit SRAM beats.
// Outputs are registered alongside the state so they line up with it.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int BEAT_CYCLES = 3
) (
  input logic            clk,
  input logic            nrst,
  sram_arbiter_if.slave  bus
);

  localparam int CW = cnt_w(BEAT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);

  state_e        state;
  logic [CW-1:0] cnt;
  req_t          req;
  req_t          nxt;
  logic          last_d;
  logic          gnt_d;

  logic [31:0]   dtr_q;
  logic          i_rdy_q;
  logic          d_rdy_q;
  logic          busy_q;
  logic          sv_q;
  logic          srw_q;
  logic [31:0]   sa_q;
  logic [15:0]   sd_q;

  rr_arb2 u_arb (
    .req_i  (bus.i_valid),
    .req_d  (bus.d_valid),
    .last_d (last_d),
    .gnt_d  (gnt_d)
  );

  always_comb begin
    nxt.own_d = gnt_d;
    nxt.rw    = gnt_d ? bus.d_rw : bus.i_rw;
    nxt.wa    = gnt_d ? bus.d_addr[31:2]
                      : bus.i_addr[31:2];
    nxt.dtw   = gnt_d ? bus.d_dtw : bus.i_dtw;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      req     <= '0;
      last_d  <= 1'b1;
      dtr_q   <= '0;
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      srw_q   <= 1'b0;
      sa_q    <= '0;
      sd_q    <= '0;
    end else begin
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_valid | bus.d_valid) begin
            req    <= nxt;
            state  <= LO;
            cnt    <= '0;
            busy_q <= 1'b1;
            sv_q   <= 1'b1;
            srw_q  <= nxt.rw;
            sa_q   <= {nxt.wa, HALF_LO};
            sd_q   <= nxt.rw ? nxt.dtw[15:0] : '0;
          end
        end
        LO: begin
          if (cnt == LAST) begin
            if (!req.rw) dtr_q[15:0] <= bus.sram_din;
            state <= GAP;
            sv_q  <= 1'b0;
            sa_q  <= '0;
            sd_q  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          state <= HI;
          cnt   <= '0;
          sv_q  <= 1'b1;
          sa_q  <= {req.wa, HALF_HI};
          sd_q  <= req.rw ? req.dtw[31:16] : '0;
        end
        HI: begin
          if (cnt == LAST) begin
            if (!req.rw) dtr_q[31:16] <= bus.sram_din;
            state   <= DONE;
            sv_q    <= 1'b0;
            srw_q   <= 1'b0;
            sa_q    <= '0;
            sd_q    <= '0;
            i_rdy_q <= ~req.own_d;
            d_rdy_q <= req.own_d;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          last_d <= req.own_d;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dtr        = dtr_q;
  assign bus.i_ready    = i_rdy_q;
  assign bus.d_ready    = d_rdy_q;
  assign bus.busy       = busy_q;
  assign bus.sram_valid = sv_q;
  assign bus.sram_rw    = srw_q;
  assign bus.sram_addri = sa_q;
  assign bus.sram_dtw   = sd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level timeline model plus
// directed literal scenarios and randomized two-port traffic.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int B = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  sram_arbiter_if bus ();

  sram_arbiter #(.BEAT_CYCLES(B)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [15:0] mem [logic [31:0]];

  function automatic logic [15:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  typedef struct packed {
    logic        ir;
    logic        dr;
    logic        bz;
    logic        v;
    logic        rw;
    logic [31:0] a;
    logic [15:0] w;
  } ob_t;

  ob_t         ring [16];
  logic        lo_set [16];
  logic        hi_set [16];
  logic [15:0] lo_val [16];
  logic [15:0] hi_val [16];
  logic [31:0] m_dtr = '0;
  logic        m_last_d = 1'b1;
  int          free_at = 0;

  ob_t  tq [$];
  logic rq_own [$];
  int   rq_cyc [$];

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) begin
      ring[k] = '0;
      lo_set[k] = 1'b0;
      hi_set[k] = 1'b0;
      lo_val[k] = '0;
      hi_val[k] = '0;
    end
    m_dtr = '0;
    m_last_d = 1'b1;
    free_at = 0;
  endfunction

  initial model_reset();

  // SRAM side: memory absorbs write beats, din follows the address
  always @(posedge clk) begin
    #1;
    if (bus.sram_valid && bus.sram_rw)
      mem[bus.sram_addri] = bus.sram_dtw;
    bus.sram_din = bus.sram_valid ? mrd(bus.sram_addri)
                                  : 16'($urandom);
  end

  always @(negedge clk) begin : cmp
    ob_t act;
    ob_t e;
    int s;
    logic own;
    logic rw;
    logic [31:0] a;
    logic [31:0] dw;
    s = cyc % 16;
    act = {bus.i_ready, bus.d_ready, bus.busy,
           bus.sram_valid, bus.sram_rw,
           bus.sram_addri, bus.sram_dtw};
    tq.push_back(act);
    if (!nrst) begin
      model_reset();
    end else begin
      if (lo_set[s]) m_dtr[15:0] = lo_val[s];
      if (hi_set[s]) m_dtr[31:16] = hi_val[s];
      e = ring[s];
      chk("outputs", 64'(act), 64'(e));
      chk("dtr", 64'(bus.dtr), 64'(m_dtr));
      chk("one_ready", 64'(bus.i_ready & bus.d_ready), 64'd0);
      if (bus.i_ready | bus.d_ready) begin
        rq_own.push_back(bus.d_ready);
        rq_cyc.push_back(cyc);
      end
      ring[s] = '0;
      lo_set[s] = 1'b0;
      hi_set[s] = 1'b0;
      if (cyc >= free_at && (bus.i_valid | bus.d_valid)) begin
        own = (bus.i_valid & bus.d_valid) ? ~m_last_d
                                          : bus.d_valid;
        rw = own ? bus.d_rw : bus.i_rw;
        a  = own ? bus.d_addr : bus.i_addr;
        a  = a & 32'hFFFF_FFFC;
        dw = own ? bus.d_dtw : bus.i_dtw;
        for (int k = 1; k <= B; k++)
          ring[(cyc + k) % 16] =
            {2'b00, 1'b1, 1'b1, rw, a,
             rw ? dw[15:0] : 16'h0};
        ring[(cyc + B + 1) % 16] =
          {2'b00, 1'b1, 1'b0, rw, 32'h0, 16'h0};
        for (int k = B + 2; k <= 2 * B + 1; k++)
          ring[(cyc + k) % 16] =
            {2'b00, 1'b1, 1'b1, rw, a + 32'd2,
             rw ? dw[31:16] : 16'h0};
        ring[(cyc + 2 * B + 2) % 16] =
          {~own, own, 1'b1, 2'b00, 32'h0, 16'h0};
        if (!rw) begin
          lo_set[(cyc + B + 1) % 16] = 1'b1;
          lo_val[(cyc + B + 1) % 16] = mrd(a);
          hi_set[(cyc + 2 * B + 2) % 16] = 1'b1;
          hi_val[(cyc + 2 * B + 2) % 16] = mrd(a + 32'd2);
        end
        m_last_d = own;
        free_at = cyc + 2 * B + 3;
      end
    end
  end

  task automatic issue(input logic pd, input logic rw,
                       input logic [31:0] a,
                       input logic [31:0] w);
    if (pd) begin
      bus.d_valid = 1'b1;
      bus.d_rw = rw;
      bus.d_addr = a;
      bus.d_dtw = w;
    end else begin
      bus.i_valid = 1'b1;
      bus.i_rw = rw;
      bus.i_addr = a;
      bus.i_dtw = w;
    end
  endtask

  task automatic wait_ready(input logic pd, output int rc);
    rc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pd ? bus.d_ready : bus.i_ready) begin
        rc = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL ready_timeout: port %0d got no ready in 40 cycles",
             pd);
  endtask

  task automatic agent3(input logic pd);
    int rc;
    for (int j = 0; j < 3; j++) begin
      issue(pd, 1'b0, 32'h0000_6000 + 32'(j * 4 + (pd ? 'h100 : 0)),
            32'h0);
      wait_ready(pd, rc);
      @(posedge clk);
      #1;
    end
    if (pd) bus.d_valid = 1'b0;
    else bus.i_valid = 1'b0;
  endtask

  task automatic agent_rand(input logic pd, input int n);
    int rc;
    logic [31:0] a;
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 1) == 0) begin
        if (pd) bus.d_valid = 1'b0;
        else bus.i_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 7) == 0)
        a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        a = 32'h0000_0100 + 32'($urandom_range(0, 31));
      issue(pd, 1'($urandom), a, $urandom);
      wait_ready(pd, rc);
      @(posedge clk);
      #1;
    end
    if (pd) bus.d_valid = 1'b0;
    else bus.i_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int rc;
    int hits;
    bus.i_valid = 1'b0;
    bus.i_rw = 1'b0;
    bus.i_addr = '0;
    bus.i_dtw = '0;
    bus.d_valid = 1'b0;
    bus.d_rw = 1'b0;
    bus.d_addr = '0;
    bus.d_dtw = '0;
    bus.sram_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_valid", 64'(bus.sram_valid), 64'd0);
    chk("reset_dtr", 64'(bus.dtr), 64'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // I read with known SRAM contents
    mem[32'h1000] = 16'hBEEF;
    mem[32'h1002] = 16'hDEAD;
    tq.delete();
    t0 = cyc;
    issue(1'b0, 1'b0, 32'h0000_1000, 32'h0);
    wait_ready(1'b0, rc);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("t1_latency", 64'(rc - t0), 64'd8);
    chk("t1_dtr", 64'(bus.dtr), 64'hDEAD_BEEF);
    for (int k = 1; k <= 3; k++)
      chk("t1_lo_addr", 64'(tq[k].a), 64'h1000);
    chk("t1_gap", 64'({tq[4].v, tq[4].a}), 64'h0);
    for (int k = 5; k <= 7; k++)
      chk("t1_hi_addr", 64'(tq[k].a), 64'h1002);

    // D write, unaligned address bits ignored
    tq.delete();
    t0 = cyc;
    issue(1'b1, 1'b1, 32'h0000_2006, 32'h1234_5678);
    wait_ready(1'b1, rc);
    @(posedge clk);
    #1;
    bus.d_valid = 1'b0;
    chk("t2_latency", 64'(rc - t0), 64'd8);
    chk("t2_lo", 64'({tq[1].rw, tq[1].a, tq[1].w}),
        {15'd0, 1'b1, 32'h2004, 16'h5678});
    chk("t2_hi", 64'({tq[5].rw, tq[5].a, tq[5].w}),
        {15'd0, 1'b1, 32'h2006, 16'h1234});
    chk("t2_dtr", 64'(bus.dtr), 64'hDEAD_BEEF);

    // both ports contend for three requests each
    rq_own.delete();
    rq_cyc.delete();
    fork
      agent3(1'b0);
      agent3(1'b1);
    join
    chk("t3_count", 64'(rq_own.size()), 64'd6);
    if (rq_own.size() == 6) begin
      for (int k = 0; k < 6; k++)
        chk("t3_order", 64'(rq_own[k]), 64'(k % 2));
      for (int k = 1; k < 6; k++)
        chk("t3_spacing", 64'(rq_cyc[k] - rq_cyc[k-1]), 64'd9);
    end
    repeat (2) @(posedge clk);
    #1;

    // reset in the 2nd HI cycle drops the access
    issue(1'b0, 1'b0, 32'h0000_3000, 32'h0);
    t0 = cyc;
    repeat (6) @(posedge clk);
    #1;
    nrst = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    chk("t4_valid", 64'(bus.sram_valid), 64'd0);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_ready", 64'({bus.i_ready, bus.d_ready}), 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    rq_own.delete();
    repeat (12) @(posedge clk);
    #1;
    chk("t4_no_ready", 64'(rq_own.size()), 64'd0);
    mem[32'h3000] = 16'hCAFE;
    mem[32'h3002] = 16'hF00D;
    t0 = cyc;
    issue(1'b0, 1'b0, 32'h0000_3000, 32'h0);
    wait_ready(1'b0, rc);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("t4_latency", 64'(rc - t0), 64'd8);
    chk("t4_dtr", 64'(bus.dtr), 64'hF00D_CAFE);

    // top of address space: no carry into 0
    tq.delete();
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    wait_ready(1'b1, rc);
    @(posedge clk);
    #1;
    bus.d_valid = 1'b0;
    chk("t5_lo", 64'(tq[1].a), 64'hFFFF_FFFC);
    chk("t5_hi", 64'(tq[5].a), 64'hFFFF_FFFE);
    hits = 0;
    foreach (tq[k])
      if (tq[k].v && tq[k].a == 32'h0) hits++;
    chk("t5_no_wrap", 64'(hits), 64'd0);

    // inputs changed after grant are ignored
    tq.delete();
    issue(1'b0, 1'b0, 32'h0000_4000, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    bus.i_addr = 32'h0000_5000;
    wait_ready(1'b0, rc);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("t6_lo", 64'(tq[3].a), 64'h4000);
    chk("t6_hi", 64'(tq[5].a), 64'h4002);

    fork
      agent_rand(1'b0, 30);
      agent_rand(1'b1, 30);
    join
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
